pe_row_feeder: RTL

PE_ROW_FEEDER -- requirements
Module: pe_row_feeder

---
 rtl/pe_row_feeder_pkg.sv | 16 +
 rtl/pe_row_feeder_if.sv | 32 +++
 rtl/vec_fifo.sv | 50 +++++
 rtl/pe_row_feeder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pe_row_feeder_pkg.sv
// Shared types and default sizing for the PE row feeder.
// Imported by the interface, the FIFO and the top.
package pe_row_feeder_pkg;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_IN_LEN = 8;
  localparam int unsigned DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } feed_state_e;

endpackage

// File: rtl/pe_row_feeder_if.sv
// Upstream vector handshake into the PE row feeder.
// master drives vectors, slave returns in_ready.
interface pe_row_feeder_if
  import pe_row_feeder_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int IN_LEN = DEF_IN_LEN
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_LEN-1:0] in_data;
  logic                    in_mode;
  logic                    in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/vec_fifo.sv
// Vector FIFO with extra-bit pointers; head is read combinationally.
// A write while full or a read while empty is ignored.
module vec_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pe_row_feeder.sv
// Buffers operand vectors and feeds them diagonally skewed to a PE row.
// Mode changes and job ends wait until every lane has flushed.
module pe_row_feeder
  import pe_row_feeder_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int IN_LEN = DEF_IN_LEN,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  pe_row_feeder_if.slave          up,
  output logic                    pe_en,
  output logic                    mode,
  output logic [LANES*IN_LEN-1:0] westin,
  output logic [LANES-1:0]        lane_valid,
  output logic                    done
);

  localparam int VW = LANES * IN_LEN;
  localparam int W  = VW + 2;

  feed_state_e     state;
  feed_state_e     state_n;
  logic [W-1:0]    head;
  logic [VW-1:0]   head_vec;
  logic            head_mode;
  logic            head_last;
  logic            full;
  logic            empty;
  logic            pop;
  logic            load_mode;
  logic            busy;
  logic [LANES-1:0] lane_busy;

  assign head_vec  = head[W-1:2];
  assign head_mode = head[1];
  assign head_last = head[0];

  assign up.in_ready = !full;

  vec_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .wr_en   (up.in_valid),
    .wr_data ({up.in_data, up.in_mode, up.in_last}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [k:0]             v;
    logic [k:0][IN_LEN-1:0] d;
    logic [IN_LEN-1:0]      d_in;

    assign d_in = pop ? head_vec[k*IN_LEN +: IN_LEN] : '0;

    if (k == 0) begin : g_first
      // Lane 0 registers the popped operand directly.
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          v <= '0;
          d <= '0;
        end else begin
          v <= pop;
          d <= d_in;
        end
      end
    end else begin : g_delay
      // Lane k delays the popped operand k extra cycles.
      always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
          v <= '0;
          d <= '0;
        end else begin
          v <= {v[k-1:0], pop};
          d <= {d[k-1:0], d_in};
        end
      end
    end

    assign lane_valid[k]                 = v[k];
    assign westin[k*IN_LEN +: IN_LEN]    = d[k];
    assign lane_busy[k]                  = |v;
  end

  assign busy  = |lane_busy;
  assign pe_en = |lane_valid;

  // State register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (!empty) state_n = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          if (head_mode != mode) state_n = SWITCH;
          else if (head_last)    state_n = DRAIN;
        end
      end
      SWITCH: begin
        if (!busy) state_n = STREAM;
      end
      DRAIN: begin
        if (!busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: pop, mode load strobe and done pulse.
  always_comb begin
    pop       = 1'b0;
    load_mode = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      (state == IDLE):   load_mode = !empty;
      (state == STREAM): pop       = !empty && (head_mode == mode);
      (state == SWITCH): load_mode = !busy;
      (state == DRAIN):  done      = !busy;
      default: ;
    endcase
  end

  // Mode only changes when no lane carries data.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst)        mode <= 1'b0;
    else if (load_mode) mode <= head_mode;
  end

endmodule
